seg_display_scan: RTL and testbench

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/seg_display_scan.sv | 130 +++++++++++++
 tb/tb_seg_display_scan.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment scanner.
`default_nettype none

package seg_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_DIG1  = 2'd1,
    ST_DIG2  = 2'd2,
    ST_DIG3  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } frame_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [2:0] AN_OFF      = 3'b111;
  localparam logic [2:0] AN_HUNDREDS = 3'b011;
  localparam logic [2:0] AN_TENS     = 3'b101;
  localparam logic [2:0] AN_UNITS    = 3'b110;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
`default_nettype none

module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_scan.sv
// 3-digit multiplexed display scanner with frame latching and expiry blink.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks leading zeros in hundreds/tens.
`default_nettype none

module seg_display_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value_three,
  input  logic [3:0] value_two,
  input  logic [3:0] value_one,
  input  logic       expired,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [BLK_W-1:0] blink_cnt, next_blink_cnt;
  logic             blank_phase, next_blank_phase;
  scan_state_t      state, next_state;
  frame_t           frame, next_frame;
  logic             tick;
  logic             dark;
  logic [3:0]       digit;
  logic [6:0]       digit_seg;
  logic [2:0]       next_an;
  logic [6:0]       next_seg;

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Outputs are registered from next-state values so they change on the tick edge itself.
  always_comb begin
    tick       = (pre_cnt == PRE_MAX);
    next_state = state;
    if (tick) begin
      case (state)
        ST_BLANK: next_state = ST_DIG1;
        ST_DIG1:  next_state = ST_DIG2;
        ST_DIG2:  next_state = ST_DIG3;
        default:  next_state = ST_DIG1;
      endcase
    end

    next_frame = frame;
    if (tick && (next_state == ST_DIG1))
      next_frame = '{hundreds: value_three, tens: value_two, units: value_one};

    next_blink_cnt   = blink_cnt;
    next_blank_phase = blank_phase;
    if (!expired) begin
      next_blink_cnt   = '0;
      next_blank_phase = 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_MAX) begin
        next_blink_cnt   = '0;
        next_blank_phase = ~blank_phase;
      end else begin
        next_blink_cnt = blink_cnt + 1'b1;
      end
    end

    digit   = next_frame.units;
    next_an = AN_OFF;
    dark    = 1'b0;
    case (next_state)
      ST_DIG1: begin
        digit   = next_frame.hundreds;
        next_an = AN_HUNDREDS;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        dark    = (next_frame.hundreds == 4'd0);
`endif
      end
      ST_DIG2: begin
        digit   = next_frame.tens;
        next_an = AN_TENS;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        dark    = (next_frame.hundreds == 4'd0) && (next_frame.tens == 4'd0);
`endif
      end
      ST_DIG3: begin
        digit   = next_frame.units;
        next_an = AN_UNITS;
      end
      default: dark = 1'b1;
    endcase
    if (next_blank_phase)
      dark = 1'b1;

    next_seg = SEG_OFF;
    if (dark)
      next_an = AN_OFF;
    else
      next_seg = digit_seg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt     <= '0;
      state       <= ST_BLANK;
      frame       <= '0;
      blink_cnt   <= '0;
      blank_phase <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
      state       <= next_state;
      frame       <= next_frame;
      blink_cnt   <= next_blink_cnt;
      blank_phase <= next_blank_phase;
      an          <= next_an;
      seg         <= next_seg;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scan.sv
// Randomized self-checking bench for seg_display_scan against a cycle-count model.
`default_nettype none

module tb_seg_display_scan;

  localparam int RD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] v3 = 4'd0, v2 = 4'd0, v1 = 4'd0;
  logic       expired = 1'b0;
  logic [2:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;          // edges since reset release
  int exp_ticks = 0;    // scan ticks seen while expired stayed high
  int lat [3] = '{0, 0, 0};

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  always #5 clk = ~clk;

  seg_display_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_three (v3),
    .value_two   (v2),
    .value_one   (v1),
    .expired     (expired),
    .an          (an),
    .seg         (seg)
  );

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cyc=%0d t=%0t)", tag, got, want, cyc, $time);
    end
  endtask

  function automatic int cur_pos();
    return (cyc < RD) ? -1 : ((cyc / RD) - 1) % 3;
  endfunction

  task automatic step();
    int         pos;
    logic       dark;
    logic [2:0] want_an;
    @(posedge clk);
    if (!reset) begin
      cyc = 0;
      exp_ticks = 0;
      lat = '{0, 0, 0};
    end else begin
      cyc++;
      if (cyc % RD == 0) begin
        if (((cyc / RD) - 1) % 3 == 0) begin
          lat[0] = int'(v3);
          lat[1] = int'(v2);
          lat[2] = int'(v1);
        end
        if (expired) exp_ticks++;
      end
      if (!expired) exp_ticks = 0;
    end
    #1;
    pos = cur_pos();
    if (pos < 0) begin
      check("an_idle", {4'b0, an}, 7'b0000111);
      check("seg_idle", seg, 7'h7F);
    end else begin
      want_an = ~(3'b100 >> pos);
      dark = expired && (((exp_ticks / BD) % 2) == 1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (pos == 0 && lat[0] == 0) dark = 1'b1;
      if (pos == 1 && lat[0] == 0 && lat[1] == 0) dark = 1'b1;
`endif
      if (dark) begin
        check("an_dark", {4'b0, an}, 7'b0000111);
      end else begin
        check("an_digit", {4'b0, an}, {4'b0, want_an});
        check("seg_digit", seg, seg_ref[lat[pos]]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; v3 = 4'd1; v2 = 4'd2; v1 = 4'd3;
    repeat (3) step();
    reset = 1'b1;
    repeat (30) step();

    // units change while tens is displayed must wait for the next frame
    for (int i = 0; i < 12 && cur_pos() != 1; i++) step();
    v1 = 4'd7;
    repeat (24) step();

    v2 = 4'hC;
    repeat (24) step();

    v3 = 4'd0; v2 = 4'd0; v1 = 4'd0; expired = 1'b1;
    repeat (48) step();
    expired = 1'b0;
    repeat (12) step();

    v1 = 4'd5;
    repeat (24) step();

    // reset in the middle of a frame
    for (int i = 0; i < 12 && cur_pos() != 1; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (20) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) v3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) v2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) v1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) expired = ~expired;
      reset = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
